// File: rtl/id_decode_stage.sv
// id_decode_stage: RV32I decoder for the ALU-control path, with an output register
// and a skid register so that in_ready_o can come straight from a flop.
module id_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] instr_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [2:0]      aluop_o,
    output logic [2:0]      func3_o,
    output logic            func7_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [XLEN-1:0] imm_o,
    output logic            reg_write_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic            alu_src_o,
    output logic            illegal_o
);
    typedef struct packed {
        logic [2:0]      aluop;
        logic [2:0]      func3;
        logic            func7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            alu_src;
        logic            illegal;
    } bundle_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    bundle_t            w_dec;
    bundle_t            r_out;
    bundle_t            r_skid;
    logic signed [31:0] w_imm;
    logic [31:0]        w_i;
    logic               r_out_valid;
    logic               r_skid_valid;
    logic               r_in_ready;
    logic               w_accept;
    logic               w_load;
    logic               w_skid_next;

    assign w_i = instr_i[31:0];

    always_comb begin
        w_dec       = '0;
        w_imm       = '0;
        w_dec.func3 = w_i[14:12];
        w_dec.rd    = w_i[11:7];
        w_dec.rs1   = w_i[19:15];
        w_dec.rs2   = w_i[24:20];
        case (w_i[6:0])
            OP_R: begin
                w_dec.reg_write = 1'b1;
                w_dec.func7     = w_i[30];
            end
            OP_IMM: begin
                w_dec.aluop     = 3'b001;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                // only the shift-right pair uses bit 30, so ADDI never looks like SUB
                w_dec.func7     = (w_i[14:12] == 3'b101) && w_i[30];
                w_imm           = 32'(signed'(w_i[31:20]));
            end
            OP_BR: begin
                w_dec.aluop  = 3'b010;
                w_dec.branch = 1'b1;
                w_imm        = 32'(signed'({w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0}));
            end
            OP_LOAD: begin
                w_dec.aluop     = 3'b011;
                w_dec.reg_write = 1'b1;
                w_dec.mem_read  = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_imm           = 32'(signed'(w_i[31:20]));
            end
            OP_STORE: begin
                w_dec.aluop     = 3'b011;
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_imm           = 32'(signed'({w_i[31:25], w_i[11:7]}));
            end
            OP_AUIPC, OP_LUI: begin
                w_dec.aluop     = (w_i[6:0] == OP_LUI) ? 3'b101 : 3'b100;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_imm           = {w_i[31:12], 12'b0};
            end
            OP_JAL: begin
                w_dec.aluop     = 3'b110;
                w_dec.reg_write = 1'b1;
                w_dec.jump      = 1'b1;
                w_imm           = 32'(signed'({w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0}));
            end
            OP_JALR: begin
                w_dec.aluop     = 3'b110;
                w_dec.reg_write = 1'b1;
                w_dec.jump      = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_imm           = 32'(signed'(w_i[31:20]));
            end
            default: begin
                w_dec.aluop   = 3'b111;
                w_dec.illegal = 1'b1;
            end
        endcase
        w_dec.imm = XLEN'(w_imm);
    end

    assign w_accept    = in_valid_i && r_in_ready;
    assign w_load      = !r_out_valid || out_ready_i;
    // skid fills only when the output register is stalled; any load empties it
    assign w_skid_next = w_load ? 1'b0 : (r_skid_valid || w_accept);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out        <= '0;
            r_skid       <= '0;
        end else if (flush_i) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            if (w_load) begin
                r_out_valid <= r_skid_valid || w_accept;
                if (r_skid_valid) r_out <= r_skid;
                else if (w_accept) r_out <= w_dec;
            end
            if (!w_load && w_accept) r_skid <= w_dec;
            r_skid_valid <= w_skid_next;
            r_in_ready   <= !w_skid_next;
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign aluop_o     = r_out.aluop;
    assign func3_o     = r_out.func3;
    assign func7_o     = r_out.func7;
    assign rd_o        = r_out.rd;
    assign rs1_o       = r_out.rs1;
    assign rs2_o       = r_out.rs2;
    assign imm_o       = r_out.imm;
    assign reg_write_o = r_out.reg_write;
    assign mem_read_o  = r_out.mem_read;
    assign mem_write_o = r_out.mem_write;
    assign branch_o    = r_out.branch;
    assign jump_o      = r_out.jump;
    assign alu_src_o   = r_out.alu_src;
    assign illegal_o   = r_out.illegal;
endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed vectors with hand-computed decode results and handshake timing.
module tb_id_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  aluop;
    logic [2:0]  func3;
    logic        func7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_src;
    logic        illegal;
    int          n_checks = 0;
    int          n_errors = 0;

    id_decode_stage #(.XLEN(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .instr_i(instr),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .aluop_o(aluop), .func3_o(func3), .func7_o(func7),
        .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2), .imm_o(imm),
        .reg_write_o(reg_write), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .branch_o(branch), .jump_o(jump), .alu_src_o(alu_src), .illegal_o(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // packs the strobes so one check covers them all: rw,mr,mw,br,jp,as,il
    function automatic logic [31:0] strobes();
        return {25'b0, reg_write, mem_read, mem_write, branch, jump, alu_src, illegal};
    endfunction

    initial begin
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_aluop", aluop, 0);
        check("rst_imm", imm, 0);
        check("rst_strobes", strobes(), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        step();

        in_valid = 1'b1; instr = 32'h002081B3;
        #1 check("add_pre_valid", out_valid, 0);
        step();
        check("add_valid", out_valid, 1);
        check("add_aluop", aluop, 3'b000);
        check("add_func3", func3, 0);
        check("add_func7", func7, 0);
        check("add_regs", {rd, rs1, rs2}, {5'd3, 5'd1, 5'd2});
        check("add_imm", imm, 0);
        check("add_strobes", strobes(), 7'b1000000);
        instr = 32'h407302B3;
        step();
        check("sub_func7", func7, 1);
        check("sub_regs", {rd, rs1, rs2}, {5'd5, 5'd6, 5'd7});
        instr = 32'hFFF00093;
        step();
        check("addi_aluop", aluop, 3'b001);
        check("addi_func7", func7, 0);
        check("addi_imm", imm, 32'hFFFFFFFF);
        check("addi_strobes", strobes(), 7'b1000010);
        instr = 32'h40315093;
        step();
        check("srai_func3", func3, 3'b101);
        check("srai_func7", func7, 1);
        check("srai_imm", imm, 32'h00000403);
        instr = 32'h0020A423;
        step();
        check("sw_aluop", aluop, 3'b011);
        check("sw_func3", func3, 3'b010);
        check("sw_imm", imm, 8);
        check("sw_strobes", strobes(), 7'b0010010);
        instr = 32'hFE0098E3;
        step();
        check("bne_aluop", aluop, 3'b010);
        check("bne_imm", imm, 32'hFFFFFFF0);
        check("bne_strobes", strobes(), 7'b0001000);
        instr = 32'h008000EF;
        step();
        check("jal_aluop", aluop, 3'b110);
        check("jal_imm", imm, 8);
        check("jal_strobes", strobes(), 7'b1000100);
        instr = 32'h123450B7;
        step();
        check("lui_aluop", aluop, 3'b101);
        check("lui_imm", imm, 32'h12345000);
        in_valid = 1'b0;
        step();
        check("drain_valid", out_valid, 0);

        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00100513;
        step();
        check("bp_a_ready", in_ready, 1);
        instr = 32'h00200593;
        step();
        check("bp_b_ready", in_ready, 0);
        check("bp_b_rd", rd, 10);
        instr = 32'h00300613;
        step();
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_rd", rd, 10);
        check("bp_hold_imm", imm, 1);
        out_ready = 1'b1;
        step();
        check("bp_out_b", {31'b0, out_valid, 27'b0, rd}, {31'b0, 1'b1, 27'b0, 5'd11});
        check("bp_ready_up", in_ready, 1);
        step();
        check("bp_out_c", {31'b0, out_valid, 27'b0, rd}, {31'b0, 1'b1, 27'b0, 5'd12});
        in_valid = 1'b0;
        step();
        check("bp_empty", out_valid, 0);

        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00100513;
        step();
        instr = 32'h00200593;
        step();
        check("fl_full", in_ready, 0);
        flush = 1'b1; instr = 32'h00300613;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("fl_next", {31'b0, out_valid, 27'b0, rd}, {31'b0, 1'b1, 27'b0, 5'd12});
        step();
        check("fl_no_dup", out_valid, 0);

        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00000000;
        step();
        in_valid = 1'b0;
        check("ill_flag", illegal, 1);
        check("ill_aluop", aluop, 3'b111);
        check("ill_strobes", strobes(), 7'b0000001);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_ready", in_ready, 1);
        check("arst_aluop", aluop, 0);
        check("arst_strobes", strobes(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
